// File: rtl/pllvr_reconfig_ctrl.sv
// GW1NSR PLLVR sequencer: reset pulse, dynamic IDSEL/FBDSEL/ODSEL codes, qualified lock with retry.
// Optional LOCK_LOSS_RECOVER_EN: on lock loss in RUN, relock with the same codes instead of failing.
module pllvr_reconfig_ctrl #(
    parameter int unsigned RST_CYCLES   = 16,
    parameter int unsigned LOCK_TIMEOUT = 65535,
    parameter int unsigned LOCK_STABLE  = 256,
    parameter int unsigned MAX_RETRY    = 3,
    parameter logic [5:0]  DEF_IDSEL    = 6'd8,
    parameter logic [5:0]  DEF_FBDSEL   = 6'd3,
    parameter logic [5:0]  DEF_ODSEL    = 6'd32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req,
    input  logic [5:0] req_idsel,
    input  logic [5:0] req_fbdsel,
    input  logic [5:0] req_odsel,
    output logic       ack,
    input  logic       pll_lock,
    output logic       pll_reset,
    output logic [5:0] pll_idsel,
    output logic [5:0] pll_fbdsel,
    output logic [5:0] pll_odsel,
    output logic       locked,
    output logic       busy,
    output logic       err
);

    localparam int unsigned CNT_TOP_A = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
    localparam int unsigned CNT_TOP   = (CNT_TOP_A > LOCK_STABLE) ? CNT_TOP_A : LOCK_STABLE;
    localparam int unsigned CNT_W     = (CNT_TOP < 1) ? 1 : $clog2(CNT_TOP + 1);
    localparam int unsigned RTY_W     = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

    localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STB_LAST  = CNT_W'(LOCK_STABLE - 1);
    localparam logic [RTY_W-1:0] RTY_LIMIT = RTY_W'(MAX_RETRY);

    typedef enum logic [2:0] {
        ST_RST       = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAIL      = 3'd4
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [RTY_W-1:0] r_retry;
    logic             r_lock_meta;
    logic             r_lock_s;
    logic             r_pll_reset;
    logic [5:0]       r_idsel;
    logic [5:0]       r_fbdsel;
    logic [5:0]       r_odsel;
    logic             r_ack;
    logic             r_locked;
    logic             r_busy;
    logic             r_err;

    state_t           w_state_nx;
    logic [CNT_W-1:0] w_cnt_nx;
    logic [RTY_W-1:0] w_retry_nx;
    logic [5:0]       w_idsel_nx;
    logic [5:0]       w_fbdsel_nx;
    logic [5:0]       w_odsel_nx;
    logic             w_ack_nx;
    logic             w_attempt_fail;
    logic             w_accept;
    logic             w_pll_reset_nx;
    logic             w_locked_nx;
    logic             w_busy_nx;
    logic             w_err_nx;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == {CNT_W{1'b1}}) begin
            sat_inc = v;
        end else begin
            sat_inc = v + CNT_W'(1);
        end
    endfunction

    // Two-flop synchronizer for the asynchronous PLL LOCK.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lock_meta <= 1'b0;
            r_lock_s    <= 1'b0;
        end else begin
            r_lock_meta <= pll_lock;
            r_lock_s    <= r_lock_meta;
        end
    end

    // Next-state, counters, code latching; a failed attempt or an accepted request overrides the state step.
    always_comb begin
        w_state_nx     = r_state;
        w_cnt_nx       = r_cnt;
        w_retry_nx     = r_retry;
        w_idsel_nx     = r_idsel;
        w_fbdsel_nx    = r_fbdsel;
        w_odsel_nx     = r_odsel;
        w_ack_nx       = 1'b0;
        w_attempt_fail = 1'b0;
        w_accept       = 1'b0;
        case (r_state)
            ST_RST: begin
                if (r_cnt >= RST_LAST) begin
                    w_state_nx = ST_WAIT_LOCK;
                    w_cnt_nx   = '0;
                end else begin
                    w_cnt_nx = sat_inc(r_cnt);
                end
            end
            ST_WAIT_LOCK: begin
                if (r_lock_s) begin
                    w_state_nx = ST_STABLE;
                    w_cnt_nx   = '0;
                end else if (r_cnt >= TMO_LAST) begin
                    w_attempt_fail = 1'b1;
                end else begin
                    w_cnt_nx = sat_inc(r_cnt);
                end
            end
            ST_STABLE: begin
                if (!r_lock_s) begin
                    w_attempt_fail = 1'b1;
                end else if (r_cnt >= STB_LAST) begin
                    w_state_nx = ST_RUN;
                    w_cnt_nx   = '0;
                    w_retry_nx = '0;
                end else begin
                    w_cnt_nx = sat_inc(r_cnt);
                end
            end
            ST_RUN: begin
                if (req) begin
                    w_accept = 1'b1;
                end else if (!r_lock_s) begin
`ifdef LOCK_LOSS_RECOVER_EN
                    w_state_nx = ST_RST;
                    w_cnt_nx   = '0;
                    w_retry_nx = '0;
`else
                    w_state_nx = ST_FAIL;
                    w_cnt_nx   = '0;
`endif
                end else begin
                    w_state_nx = ST_RUN;
                end
            end
            ST_FAIL: begin
                if (req) begin
                    w_accept = 1'b1;
                end else begin
                    w_state_nx = ST_FAIL;
                end
            end
            default: begin
                w_state_nx = ST_RST;
                w_cnt_nx   = '0;
                w_retry_nx = '0;
            end
        endcase

        if (w_attempt_fail) begin
            w_cnt_nx = '0;
            if (r_retry < RTY_LIMIT) begin
                w_retry_nx = r_retry + RTY_W'(1);
                w_state_nx = ST_RST;
            end else begin
                w_state_nx = ST_FAIL;
            end
        end else if (w_accept) begin
            w_state_nx  = ST_RST;
            w_cnt_nx    = '0;
            w_retry_nx  = '0;
            w_idsel_nx  = req_idsel;
            w_fbdsel_nx = req_fbdsel;
            w_odsel_nx  = req_odsel;
            w_ack_nx    = 1'b1;
        end else begin
            w_ack_nx = 1'b0;
        end
    end

    // Status outputs follow the state being entered so they change on the same edge.
    always_comb begin
        w_pll_reset_nx = (w_state_nx == ST_RST) || (w_state_nx == ST_FAIL);
        w_locked_nx    = (w_state_nx == ST_RUN);
        w_busy_nx      = !((w_state_nx == ST_RUN) || (w_state_nx == ST_FAIL));
        w_err_nx       = (w_state_nx == ST_FAIL);
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_RST;
            r_cnt       <= '0;
            r_retry     <= '0;
            r_pll_reset <= 1'b1;
            r_idsel     <= DEF_IDSEL;
            r_fbdsel    <= DEF_FBDSEL;
            r_odsel     <= DEF_ODSEL;
            r_ack       <= 1'b0;
            r_locked    <= 1'b0;
            r_busy      <= 1'b1;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_cnt       <= w_cnt_nx;
            r_retry     <= w_retry_nx;
            r_pll_reset <= w_pll_reset_nx;
            r_idsel     <= w_idsel_nx;
            r_fbdsel    <= w_fbdsel_nx;
            r_odsel     <= w_odsel_nx;
            r_ack       <= w_ack_nx;
            r_locked    <= w_locked_nx;
            r_busy      <= w_busy_nx;
            r_err       <= w_err_nx;
        end
    end

    assign ack        = r_ack;
    assign pll_reset  = r_pll_reset;
    assign pll_idsel  = r_idsel;
    assign pll_fbdsel = r_fbdsel;
    assign pll_odsel  = r_odsel;
    assign locked     = r_locked;
    assign busy       = r_busy;
    assign err        = r_err;

endmodule

// File: tb/tb_pllvr_reconfig_ctrl.sv
// Bench for pllvr_reconfig_ctrl: hand-derived timing table, corner sequences, and randomized
// traffic against a behavioural model (honours LOCK_LOSS_RECOVER_EN like the design).
module tb_pllvr_reconfig_ctrl;
    localparam int RC = 4;
    localparam int LT = 20;
    localparam int LS = 8;
    localparam int MR = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       req = 1'b0;
    logic [5:0] req_idsel = 6'd0;
    logic [5:0] req_fbdsel = 6'd0;
    logic [5:0] req_odsel = 6'd0;
    logic       pll_lock = 1'b0;
    logic       ack, pll_reset, locked, busy, err;
    logic [5:0] pll_idsel, pll_fbdsel, pll_odsel;

    always #5 clk = ~clk;

    pllvr_reconfig_ctrl #(
        .RST_CYCLES(RC), .LOCK_TIMEOUT(LT), .LOCK_STABLE(LS), .MAX_RETRY(MR)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req(req),
        .req_idsel(req_idsel), .req_fbdsel(req_fbdsel), .req_odsel(req_odsel),
        .ack(ack), .pll_lock(pll_lock), .pll_reset(pll_reset),
        .pll_idsel(pll_idsel), .pll_fbdsel(pll_fbdsel), .pll_odsel(pll_odsel),
        .locked(locked), .busy(busy), .err(err)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s (cycle %0d): got %0h expected %0h", nm, cyc, act, want);
        end
    endtask

    function automatic logic [31:0] dut_vec();
        return {9'd0, pll_reset, locked, busy, err, ack, pll_idsel, pll_fbdsel, pll_odsel};
    endfunction

    function automatic logic [31:0] mk(input bit r, input bit l, input bit b, input bit e);
        return {9'd0, r, l, b, e, 1'b0, 6'd8, 6'd3, 6'd32};
    endfunction

    // Behavioural model: phase + elapsed cycles in phase, lock seen through a 2-deep history.
    localparam int M_PULSE = 0, M_WAIT = 1, M_QUAL = 2, M_RUN = 3, M_FAILED = 4;
    int         m_mode, m_t, m_tries;
    bit         m_ack;
    logic [5:0] m_id, m_fb, m_od;
    bit         hist[$];

    function automatic void model_reset();
        m_mode = M_PULSE; m_t = 0; m_tries = 0; m_ack = 1'b0;
        m_id = 6'd8; m_fb = 6'd3; m_od = 6'd32;
        hist.delete(); hist.push_back(1'b0); hist.push_back(1'b0);
    endfunction

    function automatic void attempt_failed();
        m_t = 0;
        if (m_tries < MR) begin
            m_tries++;
            m_mode = M_PULSE;
        end else begin
            m_mode = M_FAILED;
        end
    endfunction

    function automatic void model_edge();
        bit ls;
        ls = hist.pop_front();
        hist.push_back(pll_lock);
        m_ack = 1'b0;
        if ((m_mode == M_RUN || m_mode == M_FAILED) && req) begin
            m_id = req_idsel; m_fb = req_fbdsel; m_od = req_odsel;
            m_tries = 0; m_mode = M_PULSE; m_t = 0; m_ack = 1'b1;
        end else begin
            case (m_mode)
                M_PULSE: begin
                    m_t++;
                    if (m_t == RC) begin m_mode = M_WAIT; m_t = 0; end
                end
                M_WAIT: begin
                    if (ls) begin m_mode = M_QUAL; m_t = 0; end
                    else begin
                        m_t++;
                        if (m_t == LT) attempt_failed();
                    end
                end
                M_QUAL: begin
                    if (!ls) attempt_failed();
                    else begin
                        m_t++;
                        if (m_t == LS) begin m_mode = M_RUN; m_tries = 0; end
                    end
                end
                M_RUN: begin
                    if (!ls) begin
`ifdef LOCK_LOSS_RECOVER_EN
                        m_mode = M_PULSE; m_t = 0; m_tries = 0;
`else
                        m_mode = M_FAILED;
`endif
                    end
                end
                default: ;
            endcase
        end
    endfunction

    function automatic logic [31:0] model_vec();
        bit r, l, b, e;
        r = (m_mode == M_PULSE) || (m_mode == M_FAILED);
        l = (m_mode == M_RUN);
        b = !((m_mode == M_RUN) || (m_mode == M_FAILED));
        e = (m_mode == M_FAILED);
        return {9'd0, r, l, b, e, m_ack, m_id, m_fb, m_od};
    endfunction

    task automatic step();
        @(posedge clk);
        model_edge();
        cyc++;
        @(negedge clk);
        check("model", dut_vec(), model_vec());
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req = 1'b0;
        #1;
        model_reset();
        check("async reset values", dut_vec(), mk(1'b1, 1'b0, 1'b1, 1'b0));
        @(negedge clk);
        rst_n = 1'b1;
        cyc = 0;
    endtask

    typedef struct {
        int          lock_on;
        int          at;
        logic [31:0] want;
        string       nm;
    } vec_t;

    vec_t tbl[17];
    int   acks;
    int   burst;

    initial begin
        tbl[0]  = '{6,   0,  mk(1, 0, 1, 0), "t1 reset c0"};
        tbl[1]  = '{6,   3,  mk(1, 0, 1, 0), "t1 reset c3"};
        tbl[2]  = '{6,   4,  mk(0, 0, 1, 0), "t1 release c4"};
        tbl[3]  = '{6,   16, mk(0, 0, 1, 0), "t1 qualifying c16"};
        tbl[4]  = '{6,   17, mk(0, 1, 0, 0), "t1 locked c17"};
        tbl[5]  = '{6,   18, mk(0, 1, 0, 0), "t1 locked c18"};
        tbl[6]  = '{0,   12, mk(0, 0, 1, 0), "early lock c12"};
        tbl[7]  = '{0,   13, mk(0, 1, 0, 0), "early lock c13"};
        tbl[8]  = '{999, 23, mk(0, 0, 1, 0), "t2 last wait c23"};
        tbl[9]  = '{999, 24, mk(1, 0, 1, 0), "t2 retry c24"};
        tbl[10] = '{999, 71, mk(0, 0, 1, 0), "t2 last wait c71"};
        tbl[11] = '{999, 72, mk(1, 0, 0, 1), "t2 fail c72"};
        tbl[12] = '{999, 90, mk(1, 0, 0, 1), "t2 fail sticky"};
        tbl[13] = '{22,  36, mk(0, 0, 1, 0), "timeout then lock c36"};
        tbl[14] = '{22,  37, mk(0, 1, 0, 0), "timeout then lock c37"};
        tbl[15] = '{20,  30, mk(0, 0, 1, 0), "late lock c30"};
        tbl[16] = '{20,  31, mk(0, 1, 0, 0), "late lock c31"};

        #2;
        foreach (tbl[i]) begin
            do_reset();
            for (int c = 0; c <= tbl[i].at; c++) begin
                pll_lock = (c >= tbl[i].lock_on);
                if (c == tbl[i].at) check(tbl[i].nm, dut_vec(), tbl[i].want);
                else step();
            end
        end

        // Runtime request from RUN
        do_reset(); pll_lock = 1'b1;
        while (cyc < 13) step();
        check("t3 locked before req", {31'd0, locked}, 32'd1);
        req = 1'b1; req_idsel = 6'd4; req_fbdsel = 6'd10; req_odsel = 6'd16;
        step();
        check("t3 ack and codes", {11'd0, ack, pll_idsel, pll_fbdsel, pll_odsel, pll_reset, locked},
              {11'd0, 1'b1, 6'd4, 6'd10, 6'd16, 1'b1, 1'b0});
        req = 1'b0;
        step();
        check("t3 ack one cycle", {31'd0, ack}, 32'd0);
        while (cyc < 17) step();
        check("t3 reset held", {31'd0, pll_reset}, 32'd1);
        step();
        check("t3 reset released", {31'd0, pll_reset}, 32'd0);
        while (cyc < 27) step();
        check("t3 relocked", {30'd0, locked, busy}, 32'd2);

        // Lock glitch during qualification
        do_reset(); pll_lock = 1'b1;
        while (cyc < 8) step();
        pll_lock = 1'b0; step();
        pll_lock = 1'b1; step();
        check("t4 still qualifying", {29'd0, pll_reset, locked, busy}, 32'd1);
        step();
        check("t4 retry reset", {29'd0, pll_reset, busy, err}, 32'd6);
        while (cyc < 23) step();
        check("t4 count restarted", {31'd0, locked}, 32'd0);
        step();
        check("t4 relocked", {31'd0, locked}, 32'd1);

        // Lock loss in RUN
        do_reset(); pll_lock = 1'b1;
        while (cyc < 15) step();
        pll_lock = 1'b0;
        step(); step();
        check("t5 locked before loss", {31'd0, locked}, 32'd1);
        step();
`ifdef LOCK_LOSS_RECOVER_EN
        check("t5 auto relock start", {28'd0, pll_reset, locked, busy, err}, 32'd10);
        pll_lock = 1'b1;
        while (cyc < 31) step();
        check("t5 auto relocked", {30'd0, locked, err}, 32'd2);
`else
        check("t5 fail on loss", {28'd0, pll_reset, locked, busy, err}, 32'd9);
        pll_lock = 1'b1;
        req = 1'b1; req_idsel = 6'd5; req_fbdsel = 6'd6; req_odsel = 6'd7;
        step();
        check("t5 recover ack", {12'd0, ack, err, pll_idsel, pll_fbdsel, pll_odsel},
              {12'd0, 1'b1, 1'b0, 6'd5, 6'd6, 6'd7});
        req = 1'b0;
        while (cyc < 32) step();
        check("t5 recovered", {30'd0, locked, err}, 32'd2);
`endif

        // Request while not in RUN, then async reset mid-qualification
        do_reset(); pll_lock = 1'b1;
        while (cyc < 4) step();
        req = 1'b1; req_idsel = 6'd1; req_fbdsel = 6'd2; req_odsel = 6'd3;
        acks = 0;
        while (cyc < 13) begin step(); acks += int'(ack); end
        check("t6 no ack before RUN", acks, 32'd0);
        check("t6 run reached", {31'd0, locked}, 32'd1);
        step();
        check("t6 ack in RUN", {13'd0, ack, pll_idsel, pll_fbdsel, pll_odsel},
              {13'd0, 1'b1, 6'd1, 6'd2, 6'd3});
        req = 1'b0;
        while (cyc < 20) step();
        req = 1'b1; req_idsel = 6'd9; req_fbdsel = 6'd9; req_odsel = 6'd9;
        step(); step();
        check("t6 mid stable", {29'd0, pll_reset, busy, locked}, 32'd2);
        do_reset();
        pll_lock = 1'b1;
        while (cyc < 20) step();
        check("t6 dropped req, default codes", {14'd0, pll_idsel, pll_fbdsel, pll_odsel},
              {14'd0, 6'd8, 6'd3, 6'd32});

        // Randomized traffic against the model
        do_reset();
        burst = 0;
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 599) == 0) do_reset();
            if (burst == 0) begin
                pll_lock = ($urandom_range(0, 3) != 0);
                burst = $urandom_range(1, 40);
            end
            burst--;
            if (!req && $urandom_range(0, 29) == 0) begin
                req = 1'b1;
                req_idsel = 6'($urandom); req_fbdsel = 6'($urandom); req_odsel = 6'($urandom);
            end
            step();
            if (m_ack) req = 1'b0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
